// File: rtl/execute_unit_mc.sv
// rtl/execute_unit_mc.sv - handshaked execute stage: forwarding, ALU, branches, CNZ flags
// Optional feature macro EXEC_MUL_EN: op D becomes an iterative shift-add multiplier driven by an FSM.
module execute_unit_mc #(
    parameter int DATA_W  = 16,
    parameter int REG_AW  = 3,
    parameter int PC_W    = 32,
    parameter int SHAMT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          alu_op,
    input  logic [REG_AW-1:0]   rdest,
    input  logic [REG_AW-1:0]   rsrc,
    input  logic [DATA_W-1:0]   read_data1,
    input  logic [DATA_W-1:0]   read_data2,
    input  logic [DATA_W-1:0]   imm,
    input  logic                imm_sel,
    input  logic [SHAMT_W-1:0]  shamt,
    input  logic                reg_write,
    input  logic [REG_AW-1:0]   wr_addr,
    input  logic [2:0]          jump_sel,
    input  logic                flag_en,
    input  logic                flag_restore,
    input  logic [2:0]          flag_restore_val,
    input  logic                mem_wb_reg_write,
    input  logic [REG_AW-1:0]   mem_wb_rdest,
    input  logic [DATA_W-1:0]   mem_wb_data,
    input  logic [PC_W-1:0]     pc_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   result_out,
    output logic [REG_AW-1:0]   wr_addr_out,
    output logic                reg_write_out,
    output logic [2:0]          flags_out,
    output logic                branch_taken,
    output logic [PC_W-1:0]     new_pc
);
    logic              accept, is_mul, cond, upd_zn, upd_c, alu_c;
    logic [DATA_W-1:0] op_a, op_b, rs_val, alu_res;
    logic [DATA_W:0]   wide;
    logic [2:0]        flags_nxt;

`ifdef EXEC_MUL_EN
    localparam int CNT_W = $clog2(DATA_W);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    state_t             state;
    logic [DATA_W-1:0]  mul_a, mul_b, mul_acc;
    logic [CNT_W-1:0]   mul_cnt;
    logic [REG_AW-1:0]  mul_wr_addr;
    logic               mul_reg_write, mul_flag_en;
    assign is_mul   = (alu_op == 4'hD);
    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
`else
    assign is_mul   = 1'b0;
    assign in_ready = !out_valid || out_ready;
`endif
    assign accept = in_valid && in_ready;

    // EX/MEM is the younger producer, so it beats MEM/WB.
    always_comb begin
        if (out_valid && reg_write_out && wr_addr_out == rdest)   op_a = result_out;
        else if (mem_wb_reg_write && mem_wb_rdest == rdest)       op_a = mem_wb_data;
        else                                                      op_a = read_data1;
        if (out_valid && reg_write_out && wr_addr_out == rsrc)    rs_val = result_out;
        else if (mem_wb_reg_write && mem_wb_rdest == rsrc)        rs_val = mem_wb_data;
        else                                                      rs_val = read_data2;
        op_b = imm_sel ? imm : rs_val;
    end

    always_comb begin
        alu_res = op_a;
        alu_c   = flags_out[2];
        upd_zn  = 1'b0;
        upd_c   = 1'b0;
        wide    = '0;
        case (alu_op)
            4'h1: begin alu_res = ~op_a; upd_zn = 1'b1; end
            4'h2: begin wide = {1'b0, op_a} + {{DATA_W{1'b0}}, 1'b1}; upd_zn = 1'b1; upd_c = 1'b1; end
            4'h3: begin wide = {1'b0, op_a} - {{DATA_W{1'b0}}, 1'b1}; upd_zn = 1'b1; upd_c = 1'b1; end
            4'h4: begin wide = {1'b0, op_a} + {1'b0, op_b}; upd_zn = 1'b1; upd_c = 1'b1; end
            4'h5: begin wide = {1'b0, op_a} - {1'b0, op_b}; upd_zn = 1'b1; upd_c = 1'b1; end
            4'h6: begin alu_res = op_a & op_b; upd_zn = 1'b1; end
            4'h7: begin alu_res = op_a | op_b; upd_zn = 1'b1; end
            4'h8: begin
                wide = {1'b0, op_a} << shamt;
                alu_res = wide[DATA_W-1:0];
                alu_c = (shamt == '0) ? flags_out[2] : wide[DATA_W];
                upd_zn = 1'b1; upd_c = 1'b1;
            end
            4'h9: begin
                wide = {op_a, 1'b0} >> shamt;
                alu_res = wide[DATA_W:1];
                alu_c = (shamt == '0) ? flags_out[2] : wide[0];
                upd_zn = 1'b1; upd_c = 1'b1;
            end
            4'hA: alu_res = op_b;
            4'hB: begin alu_c = 1'b1; upd_c = 1'b1; end
            4'hC: begin alu_c = 1'b0; upd_c = 1'b1; end
            default: alu_res = op_a;
        endcase
        if (alu_op >= 4'h2 && alu_op <= 4'h5) begin
            alu_res = wide[DATA_W-1:0];
            alu_c   = wide[DATA_W];
        end
    end

    // Flag priority on one edge: restore, then taken-jump clear, then ALU update.
    always_comb begin
        case (jump_sel)
            3'b001:  cond = flags_out[0];
            3'b010:  cond = flags_out[1];
            3'b011:  cond = flags_out[2];
            3'b100:  cond = 1'b1;
            default: cond = 1'b0;
        endcase
        flags_nxt = flags_out;
        if (flag_en && upd_zn) flags_nxt[1:0] = {alu_res[DATA_W-1], alu_res == '0};
        if (flag_en && upd_c)  flags_nxt[2]   = alu_c;
        case (jump_sel)
            3'b001:  if (cond) flags_nxt[0] = 1'b0;
            3'b010:  if (cond) flags_nxt[1] = 1'b0;
            3'b011:  if (cond) flags_nxt[2] = 1'b0;
            default: ;
        endcase
        if (flag_restore) flags_nxt = flag_restore_val;
    end

    assign branch_taken = accept && cond;
    assign new_pc = branch_taken ? {{(PC_W-DATA_W){op_a[DATA_W-1]}}, op_a} : pc_in;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid     <= 1'b0;
            result_out    <= '0;
            wr_addr_out   <= '0;
            reg_write_out <= 1'b0;
            flags_out     <= '0;
`ifdef EXEC_MUL_EN
            state         <= S_IDLE;
            mul_cnt       <= '0;
`endif
        end else begin
            if (out_ready) out_valid <= 1'b0;
            if (accept) flags_out <= flags_nxt;
            if (accept && !is_mul) begin
                result_out    <= alu_res;
                wr_addr_out   <= wr_addr;
                reg_write_out <= reg_write;
                out_valid     <= 1'b1;
            end
`ifdef EXEC_MUL_EN
            case (state)
                S_IDLE: if (accept && is_mul) begin
                    mul_a <= op_a; mul_b <= op_b; mul_acc <= '0; mul_cnt <= '0;
                    mul_wr_addr <= wr_addr; mul_reg_write <= reg_write; mul_flag_en <= flag_en;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    if (mul_b[0]) mul_acc <= mul_acc + mul_a;
                    mul_a   <= mul_a << 1;
                    mul_b   <= mul_b >> 1;
                    mul_cnt <= mul_cnt + 1'b1;
                    if (mul_cnt == CNT_W'(DATA_W - 1)) state <= S_DONE;
                end
                S_DONE: if (!out_valid || out_ready) begin
                    result_out    <= mul_acc;
                    wr_addr_out   <= mul_wr_addr;
                    reg_write_out <= mul_reg_write;
                    out_valid     <= 1'b1;
                    if (mul_flag_en) flags_out[1:0] <= {mul_acc[DATA_W-1], mul_acc == '0};
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
`endif
        end
    end
endmodule

// File: tb/tb_execute_unit_mc.sv
// tb/tb_execute_unit_mc.sv - scoreboard bench for execute_unit_mc, covering both EXEC_MUL_EN builds
module tb_execute_unit_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, in_ready, imm_sel, reg_write, flag_en, flag_restore;
    logic        mem_wb_reg_write, out_valid, out_ready, reg_write_out, branch_taken;
    logic [3:0]  alu_op, shamt;
    logic [2:0]  rdest, rsrc, wr_addr, jump_sel, flag_restore_val, mem_wb_rdest, wr_addr_out, flags_out;
    logic [15:0] read_data1, read_data2, imm, mem_wb_data, result_out;
    logic [31:0] pc_in, new_pc;

    execute_unit_mc #(.DATA_W(16), .REG_AW(3), .PC_W(32), .SHAMT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
        .rdest(rdest), .rsrc(rsrc), .read_data1(read_data1), .read_data2(read_data2),
        .imm(imm), .imm_sel(imm_sel), .shamt(shamt), .reg_write(reg_write), .wr_addr(wr_addr),
        .jump_sel(jump_sel), .flag_en(flag_en), .flag_restore(flag_restore),
        .flag_restore_val(flag_restore_val), .mem_wb_reg_write(mem_wb_reg_write),
        .mem_wb_rdest(mem_wb_rdest), .mem_wb_data(mem_wb_data), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out),
        .wr_addr_out(wr_addr_out), .reg_write_out(reg_write_out), .flags_out(flags_out),
        .branch_taken(branch_taken), .new_pc(new_pc)
    );

    typedef struct packed { logic [15:0] res; logic [2:0] wa; logic rw; } exp_t;
    typedef struct { logic [3:0] op; logic [15:0] a; logic [15:0] b; logic [3:0] sh;
                     logic [15:0] res; logic [2:0] fl; } vec_t;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[14];
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] sh, input logic [2:0] wa, input logic rw, input logic fe);
        alu_op = op; rdest = 3'd1; rsrc = 3'd2; read_data1 = a; read_data2 = b;
        imm = '0; imm_sel = 1'b0; shamt = sh; wr_addr = wa; reg_write = rw; flag_en = fe;
        jump_sel = 3'b000; flag_restore = 1'b0; flag_restore_val = 3'b000;
        mem_wb_reg_write = 1'b0; mem_wb_rdest = '0; mem_wb_data = '0; pc_in = 32'h100;
    endtask

    task automatic send(input logic [15:0] exp_res, input bit push);
        exp_t e;
        int n;
        n = 0;
        in_valid = 1'b1;
        #1;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) check("accept_timeout", in_ready, 1'b1);
        else begin
            e.res = exp_res; e.wa = wr_addr; e.rw = reg_write;
            if (push) sb_q.push_back(e);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; jump_sel = 3'b000; flag_restore = 1'b0; mem_wb_reg_write = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic restore_flags(input logic [2:0] val);
        set_instr(4'h0, 16'hAAAA, 16'h0, 4'd0, 3'd0, 1'b0, 1'b0);
        flag_restore = 1'b1; flag_restore_val = val;
        send(16'hAAAA, 1);
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) check("sb_unexpected_out", out_valid, 1'b0);
            else begin
                mon_e = sb_q.pop_front();
                check("sb_result", result_out, mon_e.res);
                check("sb_wr_addr", wr_addr_out, mon_e.wa);
                check("sb_reg_write", reg_write_out, mon_e.rw);
            end
        end
    end

    initial begin
        int seen;
        reset = 1'b0; out_ready = 1'b1;
        set_instr(4'h4, 16'h1234, 16'h1111, 4'd0, 3'd5, 1'b1, 1'b1);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result_out, 16'h0);
        check("rst_wr_addr", wr_addr_out, 3'd0);
        check("rst_reg_write", reg_write_out, 1'b0);
        check("rst_flags", flags_out, 3'b000);
        check("rst_out_valid", out_valid, 1'b0);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // carry-out and zero on wraparound
        set_instr(4'h4, 16'hFFFF, 16'h0001, 4'd0, 3'd1, 1'b1, 1'b1);
        send(16'h0000, 1);
        check("add_wrap_flags", flags_out, 3'b101);
        idle();

        // back-to-back forwarding, then EX/MEM beats MEM/WB
        set_instr(4'h4, 16'h0005, 16'h0003, 4'd0, 3'd1, 1'b1, 1'b0);
        send(16'h0008, 1);
        set_instr(4'h5, 16'h0005, 16'h0003, 4'd0, 3'd3, 1'b1, 1'b0);
        send(16'h0005, 1);
        set_instr(4'h4, 16'h0999, 16'h0, 4'd0, 3'd4, 1'b1, 1'b0);
        rdest = 3'd3; imm_sel = 1'b1; imm = 16'h0001;
        mem_wb_reg_write = 1'b1; mem_wb_rdest = 3'd3; mem_wb_data = 16'h0100;
        send(16'h0006, 1);
        idle();
        set_instr(4'h0, 16'h7777, 16'h0, 4'd0, 3'd5, 1'b0, 1'b0);
        rdest = 3'd3; mem_wb_reg_write = 1'b1; mem_wb_rdest = 3'd3; mem_wb_data = 16'h0100;
        send(16'h0100, 1);

        vecs[0]  = '{4'h1, 16'h00FF, 16'h0000, 4'd0,  16'hFF00, 3'b110};
        vecs[1]  = '{4'h2, 16'hFFFF, 16'h0000, 4'd0,  16'h0000, 3'b101};
        vecs[2]  = '{4'h3, 16'h0000, 16'h0000, 4'd0,  16'hFFFF, 3'b110};
        vecs[3]  = '{4'h5, 16'h0005, 16'h0003, 4'd0,  16'h0002, 3'b000};
        vecs[4]  = '{4'h6, 16'hF0F0, 16'h0FF0, 4'd0,  16'h00F0, 3'b000};
        vecs[5]  = '{4'h7, 16'h8000, 16'h0001, 4'd0,  16'h8001, 3'b010};
        vecs[6]  = '{4'h8, 16'h8001, 16'h0000, 4'd1,  16'h0002, 3'b100};
        vecs[7]  = '{4'h9, 16'h0002, 16'h0000, 4'd1,  16'h0001, 3'b000};
        vecs[8]  = '{4'h8, 16'h0000, 16'h0000, 4'd0,  16'h0000, 3'b001};
        vecs[9]  = '{4'hB, 16'h1234, 16'h0000, 4'd0,  16'h1234, 3'b101};
        vecs[10] = '{4'hA, 16'h0000, 16'h8000, 4'd0,  16'h8000, 3'b101};
        vecs[11] = '{4'hC, 16'h0042, 16'h0000, 4'd0,  16'h0042, 3'b001};
        vecs[12] = '{4'h9, 16'h8000, 16'h0000, 4'd15, 16'h0001, 3'b000};
        vecs[13] = '{4'hE, 16'h4321, 16'h0000, 4'd0,  16'h4321, 3'b000};
        foreach (vecs[i]) begin
            set_instr(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, 3'd7, 1'b0, 1'b1);
            send(vecs[i].res, 1);
            check($sformatf("alu_flags_%0d", i), flags_out, vecs[i].fl);
        end

        // branches
        restore_flags(3'b001);
        check("restore_flags", flags_out, 3'b001);
        set_instr(4'h0, 16'h8000, 16'h0, 4'd0, 3'd0, 1'b0, 1'b0);
        jump_sel = 3'b001; in_valid = 1'b1; #1;
        check("jz_taken", branch_taken, 1'b1);
        check("jz_new_pc", new_pc, 32'hFFFF8000);
        send(16'h8000, 1);
        check("jz_clears_z", flags_out, 3'b000);
        set_instr(4'h0, 16'h1234, 16'h0, 4'd0, 3'd0, 1'b0, 1'b0);
        jump_sel = 3'b010; pc_in = 32'h200; in_valid = 1'b1; #1;
        check("jn_not_taken", branch_taken, 1'b0);
        check("jn_new_pc", new_pc, 32'h200);
        send(16'h1234, 1);
        restore_flags(3'b001);
        set_instr(4'h2, 16'hFFFF, 16'h0, 4'd0, 3'd0, 1'b0, 1'b1);
        jump_sel = 3'b001; in_valid = 1'b1; #1;
        check("jz_inc_new_pc", new_pc, 32'hFFFFFFFF);
        send(16'h0000, 1);
        check("jz_clear_beats_alu", flags_out, 3'b100);
        restore_flags(3'b001);
        set_instr(4'h0, 16'h0010, 16'h0, 4'd0, 3'd0, 1'b0, 1'b0);
        jump_sel = 3'b001; flag_restore = 1'b1; flag_restore_val = 3'b010;
        send(16'h0010, 1);
        check("restore_beats_jump", flags_out, 3'b010);
        set_instr(4'h0, 16'h0010, 16'h0, 4'd0, 3'd0, 1'b0, 1'b0);
        jump_sel = 3'b100; pc_in = 32'h300; in_valid = 1'b1; #1;
        check("jmp_taken", branch_taken, 1'b1);
        check("jmp_new_pc", new_pc, 32'h10);
        send(16'h0010, 1);
        check("jmp_flags_kept", flags_out, 3'b010);

        // back-pressure
        idle();
        out_ready = 1'b0;
        set_instr(4'h4, 16'h0001, 16'h0001, 4'd0, 3'd4, 1'b1, 1'b0);
        send(16'h0002, 1);
        set_instr(4'h7, 16'h0002, 16'h0001, 4'd0, 3'd5, 1'b1, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_result_held", result_out, 16'h0002);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(16'h0003, 1);
        check("bp_second_out", result_out, 16'h0003);
        idle();

        restore_flags(3'b100);
`ifdef EXEC_MUL_EN
        set_instr(4'hD, 16'h0003, 16'h0007, 4'd0, 3'd6, 1'b1, 1'b1);
        send(16'h0015, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("mul_busy_in_ready", in_ready, 1'b0);
            check("mul_busy_out_valid", out_valid, 1'b0);
            @(posedge clk); #1;
        end
        check("mul_not_early", out_valid, 1'b0);
        @(posedge clk); #1;
        check("mul_out_valid", out_valid, 1'b1);
        check("mul_result", result_out, 16'h0015);
        check("mul_flags", flags_out, 3'b100);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("mul_hold_valid", out_valid, 1'b1);
            check("mul_hold_result", result_out, 16'h0015);
            check("mul_hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        idle();
        set_instr(4'hD, 16'h0003, 16'h0007, 4'd0, 3'd6, 1'b1, 1'b1);
        send(16'h0000, 0);
        repeat (5) idle();
        reset = 1'b0;
        idle();
        reset = 1'b1;
        #1;
        check("abort_in_ready", in_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b0) seen++;
            idle();
        end
        check("abort_no_out_valid", seen, 0);
`else
        set_instr(4'hD, 16'h0055, 16'h0002, 4'd0, 3'd6, 1'b1, 1'b1);
        in_valid = 1'b1; #1;
        check("op_d_in_ready", in_ready, 1'b1);
        send(16'h0055, 1);
        check("op_d_out_valid", out_valid, 1'b1);
        check("op_d_result", result_out, 16'h0055);
        check("op_d_flags", flags_out, 3'b100);
        check("op_d_in_ready_after", in_ready, 1'b1);
        seen = 0;
`endif
        repeat (3) idle();
        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
